// File: rtl/sipo_frame_controller.sv
// sipo_frame_controller: framed MSB-first serial-to-parallel receiver with valid/ready output and sticky overrun
module sipo_frame_controller #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d, out_data_d, word;
    logic [CW-1:0] bit_count_d;
    logic out_valid_d, overrun_d;
    assign word = {shreg[WIDTH-2:0], serial_in};
    assign busy = state == SHIFT;
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        bit_count_d = bit_count;
        out_data_d = out_data;
        out_valid_d = out_valid && !out_ready;
        overrun_d = overrun && !clr_overrun;
        if (frame_start) begin
            state_d = SHIFT;
            shreg_d = serial_valid ? WIDTH'(serial_in) : '0;
            bit_count_d = serial_valid ? CW'(1) : '0;
        end else if (state == SHIFT && serial_valid) begin
            shreg_d = word;
            bit_count_d = bit_count + CW'(1);
            if (bit_count == CW'(WIDTH - 1)) begin
                state_d = IDLE;
                bit_count_d = '0;
                // a full holding register drops the new word rather than the held one
                if (!out_valid || out_ready) begin
                    out_data_d = word;
                    out_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            bit_count <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            bit_count <= bit_count_d;
            out_data <= out_data_d;
            out_valid <= out_valid_d;
            overrun <= overrun_d;
        end
    end
endmodule

// File: doc/sipo_frame_controller.md
# sipo_frame_controller

Sequences a WIDTH-bit left-shift serial-in/parallel-out register as a framed receiver. A frame is opened with a start pulse and WIDTH qualified serial bits are accepted MSB-first. The assembled word moves into a holding register and is presented on a valid/ready output port. It sits between a serial source (bit stream with per-bit valid) and a parallel word consumer, and flags an overrun when the consumer falls behind.

## Interface
- WIDTH, 4: frame/word length in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- frame_start  in  1  single-cycle pulse that opens (or restarts) a frame.
- serial_in  in  1  serial data bit.
- serial_valid  in  1  serial_in is qualified this cycle.
- out_ready  in  1  consumer accepts out_data this cycle.
- clr_overrun  in  1  clears the sticky overrun flag.
- out_data  out  WIDTH  held word; the first received bit is at the MSB.
- out_valid  out  1  out_data is valid.
- busy  out  1  a frame is in progress (state SHIFT).
- bit_count  out  $clog2(WIDTH+1)  bits accepted in the current frame.
- overrun  out  1  sticky: a completed word was dropped because the holding register was full.

## Operation
- States: IDLE, SHIFT. All outputs are registered.
- Reset (rst=0 at an edge): state IDLE; shift register 0; bit_count 0; out_data 0; out_valid 0; busy 0; overrun 0. Reset overrides every other input. A reset mid-frame discards the partial word and any held word.
- IDLE: serial_valid is ignored unless frame_start=1.
- frame_start=1 in any state:
  - go to SHIFT; clear the shift register and bit_count.
  - If serial_valid=1 in the same cycle, that bit is accepted as bit 0 and bit_count becomes 1.
  - In SHIFT this is a restart: the partial word is discarded silently and overrun is not set.
- SHIFT, each cycle with serial_valid=1 and frame_start=0:
  - shreg <= {shreg[WIDTH-2:0], serial_in}
  - bit_count <= bit_count+1
- SHIFT, cycle with serial_valid=0: all frame state holds.
- Completion: the cycle in which the WIDTH-th bit is accepted.
  - The complete word is {shreg[WIDTH-2:0], serial_in}.
  - The next state is IDLE and bit_count returns to 0.
  - The word loads into the holding register if out_valid=0 or (out_valid & out_ready) this cycle; out_valid is then 1.
  - Otherwise the word is dropped, out_data/out_valid are unchanged and overrun is set to 1.
- WIDTH=1 frames are not supported.
- frame_start in the completion cycle: completion is discarded; the frame restarts per the frame_start rule.
- Output handshake: out_valid stays high and out_data stays stable until out_valid & out_ready. Then out_valid clears next cycle unless a completion loads a new word in that same cycle. A simultaneous drain and load gives back-to-back valid words with no bubble.
- overrun: sticky until clr_overrun=1. If a set and clr_overrun occur in the same cycle, the set wins.

## Timing
- frame_start at edge E: busy=1 after E.
- Frame latency: the last bit accepted at edge N gives out_valid=1 and the new out_data after edge N. With contiguous serial_valid and the start in the same cycle as bit 0, the word is visible WIDTH cycles after the frame_start cycle.
- busy falls after the completion edge.
- bit_count counts 0..WIDTH-1 while in SHIFT and is 0 in IDLE.
- Throughput: one word every WIDTH cycles, with frame_start reissued each frame and out_ready held high.
- No combinational path from any input to any output.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs -> out_data=0000, out_valid=0, busy=0, overrun=0, bit_count=0.
- Basic frame (WIDTH=4): frame_start with serial_in=1, then bits 0,1,1 with valid each cycle, out_ready=0 -> out_data=1011 and out_valid=1 after the 4th bit; busy drops the same edge; word held until out_ready=1, then out_valid=0 next cycle.
- Gapped bits: bits 0,1,0,1 with serial_valid low for 2 cycles between each -> bit_count steps 1,2,3 only on valid cycles; out_data=0101.
- Restart: send bits 1,1, then frame_start with bit 0, then bits 0,1,0 -> out_data=0010; the partial word 11 never appears; overrun=0.
- Overrun and back-to-back: out_ready=0; frame 1 gives 1100; frame 2 (0011) completes -> out_data stays 1100 and overrun=1. Assert clr_overrun -> overrun=0. Then set out_ready=1 in the completion cycle of frame 3 (1001) -> out_valid stays high, out_data=1001 with no bubble.
- Reset mid-frame: after 2 bits, rst=0 for 1 cycle -> busy=0, bit_count=0, out_valid=0; a following full frame 0110 is received correctly.
